// File: rtl/memory_access_unit_pkg.sv
// rtl/memory_access_unit_pkg.sv - shared encodings for the memory access unit
`ifndef MEMORY_ADDR_SEL_W
`define MEMORY_ADDR_SEL_W 1
`define MEMORY_ADDR_SEL_LOAD 1'b0
`define MEMORY_ADDR_SEL_STORE 1'b1
`endif

package memory_access_unit_pkg;

    localparam logic [`MEMORY_ADDR_SEL_W-1:0] SEL_LOAD  = `MEMORY_ADDR_SEL_LOAD;
    localparam logic [`MEMORY_ADDR_SEL_W-1:0] SEL_STORE = `MEMORY_ADDR_SEL_STORE;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_LO  = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_REQ_HI  = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_RESP    = 3'd5
    } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane shifting for stores and merge/extension for loads
module mem_lane_align
    import memory_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] off,
    input  logic [1:0]                  size,
    input  logic                        zero_ext,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W-1:0]           lo_rdata,
    input  logic [DATA_W-1:0]           hi_rdata,
    output logic [DATA_W/8-1:0]         be_lo,
    output logic [DATA_W/8-1:0]         be_hi,
    output logic [DATA_W-1:0]           wdata_lo,
    output logic [DATA_W-1:0]           wdata_hi,
    output logic [DATA_W-1:0]           load_data
);

    localparam int BYTES = DATA_W / 8;

    logic [BYTES-1:0]    nmask;
    logic [2*BYTES-1:0]  be_ext;
    logic [2*DATA_W-1:0] wd_ext;
    logic [DATA_W-1:0]   rd_sh;
    logic [DATA_W-1:0]   dmask;
    logic                sign;

    always_comb begin
        nmask = '0;
        case (size)
            MEM_SIZE_B: nmask = BYTES'(1);
            MEM_SIZE_H: nmask = BYTES'(3);
            MEM_SIZE_W: nmask = BYTES'(15);
            default:    nmask = '0;
        endcase
    end

    // Shifting into a double-width vector yields the LO lanes in the low half
    // and the bytes that spill into the next bus word in the high half.
    assign be_ext   = {{BYTES{1'b0}}, nmask} << off;
    assign be_lo    = be_ext[BYTES-1:0];
    assign be_hi    = be_ext[2*BYTES-1:BYTES];
    assign wd_ext   = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
    assign wdata_lo = wd_ext[DATA_W-1:0];
    assign wdata_hi = wd_ext[2*DATA_W-1:DATA_W];

    assign rd_sh = DATA_W'({hi_rdata, lo_rdata} >> {off, 3'b000});

    always_comb begin
        dmask = '0;
        for (int i = 0; i < BYTES; i++) begin
            dmask[8*i +: 8] = {8{nmask[i]}};
        end
        sign = 1'b0;
        case (size)
            MEM_SIZE_B: sign = rd_sh[7];
            MEM_SIZE_H: sign = rd_sh[15];
            MEM_SIZE_W: sign = rd_sh[31];
            default:    sign = 1'b0;
        endcase
        load_data = (rd_sh & dmask) | ((sign && !zero_ext) ? ~dmask : '0);
    end

endmodule

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - load/store front end: address generation, split bus access, load merge
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int IMM_W    = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [`MEMORY_ADDR_SEL_W-1:0] req_sel,
    input  logic [1:0]                    req_size,
    input  logic                          req_unsigned,
    input  logic [DATA_W-1:0]             req_rdata1,
    input  logic [IMM_W-1:0]              req_imm_i,
    input  logic [IMM_W-1:0]              req_imm_s,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W/8-1:0]           mem_be,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          resp_err,
    output logic [ADDR_W-1:0]             resp_addr
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    mau_state_e state, state_n;

    logic              accept;
    logic [IMM_W-1:0]  imm_sel;
    logic [ADDR_W-1:0] imm_x, base_x, ea_d;
    logic [7:0]        span_d;
    logic              cross_d, err_d;

    logic [ADDR_W-1:0] ea_q, ea_n, ea_al_n;
    logic [1:0]        size_q, size_n;
    logic              zext_q, zext_n, store_q, store_n;
    logic              cross_q, cross_n, err_q, err_n;
    logic [DATA_W-1:0] wdata_q, wdata_n, lo_q, lo_n, hi_q, hi_n;

    logic              req_lo_n, req_hi_n, resp_n;
    logic [BYTES-1:0]  be_lo, be_hi;
    logic [DATA_W-1:0] wd_lo, wd_hi, load_data;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign imm_sel   = (req_sel == SEL_STORE) ? req_imm_s : req_imm_i;

    generate
        if (IMM_W >= ADDR_W) begin : g_imm_trunc
            assign imm_x = imm_sel[ADDR_W-1:0];
        end else begin : g_imm_sext
            assign imm_x = {{(ADDR_W-IMM_W){imm_sel[IMM_W-1]}}, imm_sel};
        end
        if (DATA_W >= ADDR_W) begin : g_base_trunc
            assign base_x = req_rdata1[ADDR_W-1:0];
        end else begin : g_base_zext
            assign base_x = {{(ADDR_W-DATA_W){1'b0}}, req_rdata1};
        end
    endgenerate

    assign ea_d    = base_x + imm_x;
    assign span_d  = 8'(ea_d[OFF_W-1:0]) + (8'd1 << req_size);
    assign cross_d = span_d > 8'(BYTES);
    assign err_d   = (req_size == 2'd3) || (cross_d && (SPLIT_EN == 0));

    // Context as it will be next cycle, so registered outputs line up with state_n.
    always_comb begin
        ea_n    = ea_q;
        size_n  = size_q;
        zext_n  = zext_q;
        store_n = store_q;
        cross_n = cross_q;
        err_n   = err_q;
        wdata_n = wdata_q;
        lo_n    = lo_q;
        hi_n    = hi_q;
        if (accept) begin
            ea_n    = ea_d;
            size_n  = req_size;
            zext_n  = req_unsigned;
            store_n = (req_sel == SEL_STORE);
            cross_n = cross_d;
            err_n   = err_d;
            wdata_n = req_wdata;
        end
        if (state == ST_WAIT_LO && mem_rvalid) lo_n = mem_rdata;
        if (state == ST_WAIT_HI && mem_rvalid) hi_n = mem_rdata;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (req_valid) state_n = err_d ? ST_RESP : ST_REQ_LO;
            ST_REQ_LO:  if (mem_gnt) state_n = store_q ? (cross_q ? ST_REQ_HI : ST_RESP) : ST_WAIT_LO;
            ST_WAIT_LO: if (mem_rvalid) state_n = cross_q ? ST_REQ_HI : ST_RESP;
            ST_REQ_HI:  if (mem_gnt) state_n = store_q ? ST_RESP : ST_WAIT_HI;
            ST_WAIT_HI: if (mem_rvalid) state_n = ST_RESP;
            ST_RESP:    state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    assign req_lo_n = (state_n == ST_REQ_LO);
    assign req_hi_n = (state_n == ST_REQ_HI);
    assign resp_n   = (state_n == ST_RESP);
    assign ea_al_n  = {ea_n[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    mem_lane_align #(
        .DATA_W(DATA_W)
    ) u_lane (
        .off      (ea_n[OFF_W-1:0]),
        .size     (size_n),
        .zero_ext (zext_n),
        .wdata    (wdata_n),
        .lo_rdata (lo_n),
        .hi_rdata (hi_n),
        .be_lo    (be_lo),
        .be_hi    (be_hi),
        .wdata_lo (wd_lo),
        .wdata_hi (wd_hi),
        .load_data(load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ea_q       <= '0;
            size_q     <= '0;
            zext_q     <= 1'b0;
            store_q    <= 1'b0;
            cross_q    <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            resp_addr  <= '0;
        end else begin
            ea_q       <= ea_n;
            size_q     <= size_n;
            zext_q     <= zext_n;
            store_q    <= store_n;
            cross_q    <= cross_n;
            err_q      <= err_n;
            wdata_q    <= wdata_n;
            lo_q       <= lo_n;
            hi_q       <= hi_n;
            mem_req    <= req_lo_n || req_hi_n;
            mem_we     <= (req_lo_n || req_hi_n) && store_n;
            if (req_lo_n)      mem_addr <= ea_al_n;
            else if (req_hi_n) mem_addr <= ea_al_n + ADDR_W'(BYTES);
            mem_be     <= req_lo_n ? be_lo : (req_hi_n ? be_hi : '0);
            mem_wdata  <= (req_lo_n && store_n) ? wd_lo : ((req_hi_n && store_n) ? wd_hi : '0);
            resp_valid <= resp_n;
            resp_err   <= resp_n && err_n;
            resp_rdata <= (resp_n && !store_n && !err_n) ? load_data : '0;
            resp_addr  <= ea_n;
        end
    end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
Parametrised load/store front end for the mincore datapath.
- Computes the effective address: rdata1 + imm_i for loads, rdata1 + imm_s for stores.
- Issues one or two aligned bus transactions over a req/gnt/rvalid handshake and splits accesses that cross a bus word boundary.
- Merges and extends load data, then returns a single-cycle response to the core.
- Sits between decode/register read and the data memory port.

Parameters:
DATA_W, 32, bus and register data width; 32 or 64; BYTES = DATA_W/8.
ADDR_W, 32, memory address width.
IMM_W, 32, immediate width; sign-extended or truncated to ADDR_W.
SPLIT_EN, 1, 1 = split misaligned crossing accesses; 0 = flag them as resp_err.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  access request
req_ready  out  1  unit idle, request accepted when valid & ready
req_sel  in  `MEMORY_ADDR_SEL_W  LOAD or STORE select
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  1  zero-extend load data
req_rdata1  in  DATA_W  base register
req_imm_i  in  IMM_W  load immediate
req_imm_s  in  IMM_W  store immediate
req_wdata  in  DATA_W  store data, right-aligned
mem_req  out  1  bus request
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  aligned address (low log2(BYTES) bits = 0)
mem_be  out  BYTES  byte enables
mem_wdata  out  DATA_W  lane-shifted write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores
resp_err  out  1  illegal size or unsplit misaligned access
resp_addr  out  ADDR_W  effective address

Behaviour:
- Reset (async, any state): FSM goes to IDLE; mem_req, mem_we, mem_be, resp_valid, resp_err go to 0; addresses and data go to 0. An in-flight bus transaction is abandoned, and the bus must tolerate mem_req dropping.
- States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP.
- req_ready = (state == IDLE). On accept, register:
  - ea = rdata1 + sext(imm), wrapping modulo 2^ADDR_W
  - off = ea[log2(BYTES)-1:0]
  - n = 1 << size
  - cross = off + n > BYTES
- Illegal size, or cross with SPLIT_EN = 0: go to RESP with err = 1; no bus access.
- REQ_LO:
  - mem_addr = ea with low bits cleared.
  - mem_be = ((1<<n)-1) << off, truncated to BYTES.
  - mem_wdata = wdata << 8*off.
  - Hold all bus outputs stable until mem_gnt.
  - On gnt: load goes to WAIT_LO; store goes to REQ_HI if cross, else RESP.
- WAIT_LO: capture mem_rdata on mem_rvalid, then go to REQ_HI if cross, else RESP.
  - rvalid arrives no earlier than the cycle after gnt; rvalid in any other state is ignored.
- REQ_HI / WAIT_HI: same handshake as LO, with:
  - mem_addr = aligned ea + BYTES (wraps)
  - mem_be = ((1<<n)-1) >> (BYTES-off)
  - mem_wdata = wdata >> 8*(BYTES-off)
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
  - Load data = ({hi,lo} >> 8*off), truncated to n bytes, then sign- or zero-extended per req_unsigned.
  - There is no response backpressure.
- Latency with zero-wait bus (gnt in the REQ cycle, rvalid in the next cycle):
  - Aligned load: resp_valid 3 cycles after accept.
  - Aligned store: 2 cycles after accept.
  - Split access: +2 cycles for loads, +1 for stores.
- Outputs are registered except req_ready, which is decoded from state.

Decomposition:
- Shared package/defines:
  - existing `MEMORY_ADDR_SEL_*
  - size encodings MEM_SIZE_B/H/W
  - FSM state encoding
- Sub-module `mem_lane_align` (combinational) provides:
  - be and wdata shifting for LO and HI
  - load merge and extension
- The FSM and address registers stay in the top module.

Test Plan:
- Aligned word load: rdata1 = 0x1000, imm_i = 4, mem_rdata = 0xDEADBEEF -> mem_addr = 0x1004, be = 0xF, resp_rdata = 0xDEADBEEF, resp_valid at cycle 3.
- Signed byte load: rdata1 = 0x2000, imm_i = -1, mem_rdata = 0x80xxxxxx -> mem_addr = 0x1FFC, be = 0x8, resp_rdata = 0xFFFFFF80; with unsigned set -> 0x00000080.
- Split word store: rdata1 = 0x100, imm_s = 3, wdata = 0xAABBCCDD -> first access addr 0x100, be 0x8, wdata 0xDD000000; second access addr 0x104, be 0x7, wdata 0x00AABBCC.
- Split half load with mem_gnt held low for 4 cycles on each access -> outputs stay stable while waiting; lo = 0x11xxxxxx, hi = 0xxxxxxx22 give resp_rdata = 0x00002211.
- SPLIT_EN = 0 with word at 0x102, and separately size = 3 -> no mem_req, resp_err = 1, resp_addr = 0x102.
- Assert rst during WAIT_HI -> mem_req and resp_valid drop to 0 immediately, req_ready = 1 next cycle, and the next request completes normally.
